morse_symbol_scheduler: RTL
===========================

// Module: morse_symbol_scheduler
// PURPOSE
//  Front-end controller for the Morse decode datapath: conditions the dot, dash, char-space and word-space keys.
//  Arbitrates simultaneous presses and inserts automatic char/word gaps after idle time.
//  Queues symbols in a small FIFO and hands them one at a time to the decoder over a valid/ready handshake.
//  Sits between the ui_in key pins and morse_top's symbol inputs.
// PARAMETERS
//  DEBOUNCE_CYCLES  16     consecutive stable cycles before a debounced key level changes (>=2)
//  GAP_CHAR_CYCLES  1000   idle cycles after last dot/dash before an auto char-space
//  GAP_WORD_CYCLES  3000   idle cycles after last dot/dash before an auto word-space (> GAP_CHAR_CYCLES)
//  FIFO_DEPTH       4      symbol queue depth (power of two, >=2)
// PORTS
//  clk          in   1  clock
//  rst_n        in   1  asynchronous reset, active-low
//  dot_btn      in   1  raw dot key (async, bouncy)
//  dash_btn     in   1  raw dash key
//  char_btn     in   1  raw char-space key
//  word_btn     in   1  raw word-space key
//  auto_gap_en  in   1  1 = generate automatic gaps; sampled every cycle
//  sym_ready    in   1  decoder accepts the head symbol
//  sym_valid    out  1  FIFO non-empty
//  sym_code     out  2  head symbol: 0 DOT, 1 DASH, 2 CHAR_SPACE, 3 WORD_SPACE
//  fifo_count   out  $clog2(FIFO_DEPTH)+1  current occupancy
//  overflow     out  1  sticky: a key event was dropped; cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; pending flags, debounced levels, idle timer and gap flags cleared.
//  - Per key: 2-FF synchroniser, then debounce. The debounced level flips on the DEBOUNCE_CYCLES-th
//    consecutive edge where the synchronised input differs from it. Any agreeing cycle zeroes the counter.
//    A debounced 0->1 transition yields a 1-cycle press event. Releases produce nothing.
//  - Pending: each event sets that code's pending flag on the next edge.
//    An event whose flag is still set is dropped and sets overflow.
//  - Arbitration: each cycle at most one pending flag is pushed, priority DOT > DASH > CHAR_SPACE > WORD_SPACE.
//    The pushed flag clears on the same edge.
//  - Push is allowed when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop happens in the same cycle.
//    Otherwise the flag stays pending (backpressure, no loss).
//  - Pop on sym_valid && sym_ready. sym_code/sym_valid/fifo_count are registered from FIFO state.
//    Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  - Latency: edge 1 = first edge sampling a clean high key. With FIFO empty and nothing pending,
//    sym_valid rises after edge DEBOUNCE_CYCLES+4.
//  - Auto gap: a push of DOT/DASH zeroes idle_cnt and sets char_due and word_due.
//    A push of CHAR_SPACE clears char_due. A push of WORD_SPACE clears char_due and word_due.
//    Otherwise idle_cnt increments, saturating at GAP_WORD_CYCLES.
//    - idle_cnt == GAP_CHAR_CYCLES-1 && char_due && auto_gap_en -> set CHAR_SPACE pending.
//    - idle_cnt == GAP_WORD_CYCLES-1 && word_due && auto_gap_en -> set WORD_SPACE pending.
//    - An auto request colliding with an already-set flag merges silently; no overflow.
//    - Auto gaps never fire before the first element after reset.
//  - auto_gap_en=0 mid-count: the timer keeps running, but no auto flags are set.
//  - Reset mid-operation: queued and pending symbols are discarded. Keys still held at release of reset
//    produce one event each after debounce.
// STRUCTURE
//  - morse_pkg:
//    - sym_t 2-bit typedef and SYM_DOT/SYM_DASH/SYM_CHAR/SYM_WORD constants; shared with morse_top's decoder.
//  - Sub-module morse_key_debounce: synchroniser + debounce counter + rise pulse, parameter DEBOUNCE_CYCLES.
//    Instantiated 4x.
//  - FIFO, arbiter and gap timer are inline.
// TESTING (DEBOUNCE_CYCLES=4, GAP_CHAR=20, GAP_WORD=60, DEPTH=4)
//  1. Clean dot press held 10 cycles, sym_ready=1 -> sym_valid high after edge 8, sym_code=0 for 1 cycle.
//     Exactly one symbol.
//  2. Dash bouncing 1-0-1-0 at 1-cycle spacing, then stable 1 -> no event during bounce;
//     one DASH once stable for 4 cycles.
//  3. Dot and word pressed on the same cycle -> DOT then WORD_SPACE on consecutive sym_valid cycles.
//     overflow stays 0.
//  4. sym_ready=0; press dot, dash, dot, dash, dot -> fifo_count 4, fifth held pending.
//     Raise ready -> order D,A,D,A,D. overflow=0.
//  5. auto_gap_en=1, single dot then idle 80 cycles -> DOT, CHAR_SPACE 20 cycles after the DOT push,
//     WORD_SPACE 60 after. No further gaps.
//  6. Press dash, drop rst_n while it is queued -> outputs 0 immediately.
//     Release with key low -> no symbol emitted.

Source files
------------

// File: rtl/morse_pkg.sv
// ============================================================================
//  Module      : morse_pkg
//  Description : Shared symbol type and codes for the Morse front-end and the
//                morse_top decoder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package morse_pkg;

    // Two-bit symbol code carried from the scheduler to the decoder
    typedef logic [1:0] sym_t;

    localparam sym_t SYM_DOT  = 2'd0;
    localparam sym_t SYM_DASH = 2'd1;
    localparam sym_t SYM_CHAR = 2'd2;
    localparam sym_t SYM_WORD = 2'd3;

    // One key per symbol code; key index equals its symbol code
    localparam int NUM_KEYS = 4;

    // Lowest-index set bit wins: DOT > DASH > CHAR_SPACE > WORD_SPACE
    function automatic sym_t highest_priority(input logic [NUM_KEYS-1:0] req);
        sym_t sel;
        sel = SYM_DOT;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel = sym_t'(i);
            end
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/morse_key_debounce.sv
// ============================================================================
//  Module      : morse_key_debounce
//  Description : Two-flop synchroniser, stability counter and rising-edge
//                press pulse for one raw mechanical key.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module morse_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    output logic o_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Bring the asynchronous key into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    // Flip the level after enough consecutive disagreeing samples; pulse on a rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_level <= r_sync2;
                    r_press <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

`default_nettype wire

// File: rtl/morse_symbol_scheduler.sv
// ============================================================================
//  Module      : morse_symbol_scheduler
//  Description : Debounces the four Morse keys, arbitrates pending symbols,
//                inserts automatic char/word gaps after idle time and queues
//                symbols for the decoder over a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module morse_symbol_scheduler #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GAP_CHAR_CYCLES = 1000,
    parameter int GAP_WORD_CYCLES = 3000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          dot_btn,
    input  logic                          dash_btn,
    input  logic                          char_btn,
    input  logic                          word_btn,
    input  logic                          auto_gap_en,
    input  logic                          sym_ready,
    output logic                          sym_valid,
    output logic [1:0]                    sym_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    import morse_pkg::*;

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDLE_W = $clog2(GAP_WORD_CYCLES + 1);

    // Key conditioning
    logic [NUM_KEYS-1:0] w_keys;
    logic [NUM_KEYS-1:0] w_press;

    assign w_keys = {word_btn, char_btn, dash_btn, dot_btn};

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        morse_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_key  (w_keys[gi]),
            .o_press(w_press[gi])
        );
    end

    // State
    logic [NUM_KEYS-1:0] r_pend;
    logic                r_overflow;
    logic [IDLE_W-1:0]   r_idle;
    logic                r_char_due;
    logic                r_word_due;
    sym_t                r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    // Handshake and arbitration
    logic                w_pop;
    logic                w_room;
    logic                w_push;
    sym_t                w_push_sym;
    logic [NUM_KEYS-1:0] w_push_1h;
    logic                w_push_elem;
    logic                w_auto_char;
    logic                w_auto_word;
    logic [NUM_KEYS-1:0] w_auto;
    logic [NUM_KEYS-1:0] w_pend_next;

    assign w_pop  = (r_count != '0) && sym_ready;
    // A full queue still accepts a push when the head leaves in the same cycle
    assign w_room = (r_count < CNT_W'(FIFO_DEPTH)) || w_pop;

    // Choose the highest-priority pending symbol when there is room for it
    always_comb begin
        w_push     = 1'b0;
        w_push_sym = SYM_DOT;
        w_push_1h  = '0;
        if (w_room && (r_pend != '0)) begin
            w_push                = 1'b1;
            w_push_sym            = highest_priority(r_pend);
            w_push_1h[w_push_sym] = 1'b1;
        end
    end

    assign w_push_elem = w_push && ((w_push_sym == SYM_DOT) || (w_push_sym == SYM_DASH));

    // Gap requests fire once when the idle timer passes each threshold
    assign w_auto_char = auto_gap_en && r_char_due && (r_idle == IDLE_W'(GAP_CHAR_CYCLES - 1));
    assign w_auto_word = auto_gap_en && r_word_due && (r_idle == IDLE_W'(GAP_WORD_CYCLES - 1));
    assign w_auto      = {w_auto_word, w_auto_char, 2'b00};

    // A key event only lands if its flag is free; auto requests merge without complaint
    assign w_pend_next = (r_pend & ~w_push_1h) | (w_press & ~r_pend) | w_auto;

    // Pending flags and the sticky dropped-event indicator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            if ((w_press & r_pend) != '0) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Idle timer since the last dot/dash and the outstanding-gap flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle     <= '0;
            r_char_due <= 1'b0;
            r_word_due <= 1'b0;
        end else if (w_push_elem) begin
            r_idle     <= '0;
            r_char_due <= 1'b1;
            r_word_due <= 1'b1;
        end else begin
            if (r_idle != IDLE_W'(GAP_WORD_CYCLES)) begin
                r_idle <= r_idle + 1'b1;
            end
            if (w_push && (w_push_sym == SYM_CHAR)) begin
                r_char_due <= 1'b0;
            end
            if (w_push && (w_push_sym == SYM_WORD)) begin
                r_char_due <= 1'b0;
                r_word_due <= 1'b0;
            end
        end
    end

    // Symbol queue storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= SYM_DOT;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_sym;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign sym_valid  = (r_count != '0);
    assign sym_code   = r_mem[r_rd_ptr];
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule

`default_nettype wire
